// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and valid/ready drain.
// Optional registered RTS flow control with hysteresis when SERTERM_RTS_EN is defined.
module uart_rx_buffer #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int HIGH_WATER = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rx,
  output logic [7:0]                    o_char,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic                          o_rts_n
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int W  = $clog2(FIFO_DEPTH);
  localparam int LW = W + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  // The IDLE detect cycle already consumed one clock, so the start sample lands
  // 2 + CLKS_PER_BIT/2 clocks after the line fall.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 2);

  if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      HIGH_WATER < 4 || HIGH_WATER > FIFO_DEPTH) begin : g_param_check
    $error("uart_rx_buffer: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic          rx_meta, rx_s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          push, push_nxt;
  logic          frame_err, frame_err_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [W-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, wr_en, overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      push      <= push_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_nxt       = bit_idx;
    shift_nxt     = shift;
    push_nxt      = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = BIT_LOAD;
            bit_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_nxt = {rx_s, shift[7:1]};
          cnt_nxt   = BIT_LOAD;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A push into a full FIFO still lands when the same cycle pops the head.
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = o_valid & i_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      overrun <= push & full & ~pop;
    end
  end

  assign o_char      = mem[rd_ptr];
  assign o_valid     = (level != '0);
  assign o_level     = level;
  assign o_frame_err = frame_err;
  assign o_overrun   = overrun;

`ifdef SERTERM_RTS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rts_n <= 1'b0;
    end else if (level >= LW'(HIGH_WATER)) begin
      o_rts_n <= 1'b1;
    end else if (level <= LW'(HIGH_WATER - 4)) begin
      o_rts_n <= 1'b0;
    end
  end
`else
  assign o_rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer: latency, ordering, glitch,
// framing error, overrun, reset mid-frame and RTS behaviour.
module tb_uart_rx_buffer;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_rx;
  logic       i_ready;
  logic [7:0] o_char;
  logic       o_valid;
  logic [4:0] o_level;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_rts_n;

  int checks = 0;
  int passes = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  uart_rx_buffer dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_char      (o_char),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_level     (o_level),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_rts_n     (o_rts_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_frame_err) ferr_cnt++;
    if (o_overrun)   ovr_cnt++;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Caller must be at posedge+1; returns at posedge+1 with the line left at the stop value.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 i_rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    #1 i_rx = stop;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    align();
    checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", o_valid); else passes++;
    checks++; if (o_level !== 5'd0) $display("FAIL rst_level: got %0d expected 0", o_level); else passes++;
    checks++; if (o_frame_err !== 1'b0) $display("FAIL rst_ferr: got %0b expected 0", o_frame_err); else passes++;
    checks++; if (o_overrun !== 1'b0) $display("FAIL rst_ovr: got %0b expected 0", o_overrun); else passes++;
    checks++; if (o_rts_n !== 1'b0) $display("FAIL rst_rts: got %0b expected 0", o_rts_n); else passes++;
  endtask

  task automatic test_single();
    int fb;
    fb = ferr_cnt;
    align();
    fork
      send_byte(8'h41, 1'b1);
      begin
        repeat (990) @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) $display("FAIL lat_early: valid %0b expected 0 at clk 990", o_valid); else passes++;
        @(posedge clk);
        #1;
        checks++; if (o_valid !== 1'b1) $display("FAIL lat_valid: valid %0b expected 1 at clk 991", o_valid); else passes++;
        checks++; if (o_char !== 8'h41) $display("FAIL lat_char: got %0h expected 41", o_char); else passes++;
      end
    join
    pop_one();
    checks++; if (o_valid !== 1'b0) $display("FAIL pop_valid: got %0b expected 0", o_valid); else passes++;
    checks++; if (ferr_cnt !== fb) $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, fb); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h0C; exp[1] = 8'h55; exp[2] = 8'hAA;
    i_ready = 1'b0;
    align();
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (o_level !== 5'd3) $display("FAIL b2b_level: got %0d expected 3", o_level); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_char !== exp[i]) $display("FAIL b2b_char%0d: got %0h expected %0h", i, o_char, exp[i]); else passes++;
      pop_one();
    end
    checks++; if (o_valid !== 1'b0) $display("FAIL b2b_empty: got %0b expected 0", o_valid); else passes++;
  endtask

  task automatic test_glitch();
    int fb;
    fb = ferr_cnt;
    align();
    i_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 i_rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++; if (o_level !== 5'd0) $display("FAIL glitch_level: got %0d expected 0", o_level); else passes++;
    checks++; if (ferr_cnt !== fb) $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, fb); else passes++;
    send_byte(8'h5A, 1'b1);
    checks++; if (o_level !== 5'd1) $display("FAIL glitch_next_level: got %0d expected 1", o_level); else passes++;
    checks++; if (o_char !== 8'h5A) $display("FAIL glitch_next_char: got %0h expected 5a", o_char); else passes++;
    pop_one();
  endtask

  task automatic test_frame_err();
    int fb, ob;
    fb = ferr_cnt; ob = ovr_cnt;
    align();
    send_byte(8'h7E, 1'b0);
    repeat (2000) @(posedge clk);
    #1;
    checks++; if (ferr_cnt - fb !== 1) $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt - fb); else passes++;
    checks++; if (o_level !== 5'd0) $display("FAIL ferr_level: got %0d expected 0", o_level); else passes++;
    checks++; if (ovr_cnt !== ob) $display("FAIL ferr_ovr: got %0d expected %0d", ovr_cnt, ob); else passes++;
    i_rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_byte(8'h31, 1'b1);
    checks++; if (o_level !== 5'd1) $display("FAIL ferr_next_level: got %0d expected 1", o_level); else passes++;
    checks++; if (o_char !== 8'h31) $display("FAIL ferr_next_char: got %0h expected 31", o_char); else passes++;
    checks++; if (ferr_cnt - fb !== 1) $display("FAIL ferr_extra: got %0d expected 1", ferr_cnt - fb); else passes++;
    pop_one();
  endtask

  task automatic test_overrun();
    int ob, lvl;
    logic rts_m;
    ob = ovr_cnt;
    rts_m = 1'b0;
    i_ready = 1'b0;
    align();
    for (int k = 0; k < 17; k++) begin
      send_byte(8'h60 + 8'(k), 1'b1);
      lvl = (k < 16) ? k + 1 : 16;
`ifdef SERTERM_RTS_EN
      if (lvl >= 12) rts_m = 1'b1; else if (lvl <= 8) rts_m = 1'b0;
`endif
      checks++; if (o_level !== 5'(lvl)) $display("FAIL ovr_fill_level%0d: got %0d expected %0d", k, o_level, lvl); else passes++;
      checks++; if (o_rts_n !== rts_m) $display("FAIL ovr_fill_rts%0d: got %0b expected %0b", k, o_rts_n, rts_m); else passes++;
    end
    checks++; if (ovr_cnt - ob !== 1) $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cnt - ob); else passes++;
    for (int i = 0; i < 16; i++) begin
      checks++; if (o_char !== 8'h60 + 8'(i)) $display("FAIL ovr_drain%0d: got %0h expected %0h", i, o_char, 8'h60 + 8'(i)); else passes++;
      pop_one();
      @(posedge clk);
      #1;
      lvl = 15 - i;
`ifdef SERTERM_RTS_EN
      if (lvl >= 12) rts_m = 1'b1; else if (lvl <= 8) rts_m = 1'b0;
`endif
      checks++; if (o_rts_n !== rts_m) $display("FAIL ovr_drain_rts%0d: got %0b expected %0b", i, o_rts_n, rts_m); else passes++;
    end
    checks++; if (o_valid !== 1'b0) $display("FAIL ovr_empty: got %0b expected 0", o_valid); else passes++;
  endtask

  task automatic test_full_pop();
    int ob;
    logic [7:0] e;
    i_ready = 1'b0;
    align();
    for (int k = 0; k < 16; k++) send_byte(8'h80 + 8'(k), 1'b1);
    checks++; if (o_level !== 5'd16) $display("FAIL fp_full: got %0d expected 16", o_level); else passes++;
    ob = ovr_cnt;
    fork
      send_byte(8'hC3, 1'b1);
      begin
        repeat (990) @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
      end
    join
    checks++; if (o_level !== 5'd16) $display("FAIL fp_level: got %0d expected 16", o_level); else passes++;
    checks++; if (ovr_cnt !== ob) $display("FAIL fp_ovr: got %0d expected %0d", ovr_cnt, ob); else passes++;
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? 8'h81 + 8'(i) : 8'hC3;
      checks++; if (o_char !== e) $display("FAIL fp_drain%0d: got %0h expected %0h", i, o_char, e); else passes++;
      pop_one();
    end
    checks++; if (o_level !== 5'd0) $display("FAIL fp_empty: got %0d expected 0", o_level); else passes++;
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    align();
    send_byte(8'h77, 1'b1);
    checks++; if (o_level !== 5'd1) $display("FAIL rm_pre_level: got %0d expected 1", o_level); else passes++;
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (572) @(posedge clk);
        #1 i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        checks++; if (o_valid !== 1'b0) $display("FAIL rm_valid: got %0b expected 0", o_valid); else passes++;
        checks++; if (o_level !== 5'd0) $display("FAIL rm_level: got %0d expected 0", o_level); else passes++;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checks++; if (o_level !== 5'd0) $display("FAIL rm_lost: got %0d expected 0", o_level); else passes++;
    send_byte(8'h20, 1'b1);
    checks++; if (o_level !== 5'd1) $display("FAIL rm_next_level: got %0d expected 1", o_level); else passes++;
    checks++; if (o_char !== 8'h20) $display("FAIL rm_next_char: got %0h expected 20", o_char); else passes++;
    pop_one();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
